// File: rtl/rr_sched_pkg.sv
// Shared types and constants for the round-robin job scheduler.
package rr_sched_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // A latched job length of zero still runs the engine for one cycle.
  localparam int ZERO_LEN_SUB = 1;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after `last`, with wrap-around.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] sel,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);
  logic [IDX_W-1:0] cand;

  always_comb begin
    sel   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        sel[cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_job_scheduler.sv
// Round-robin scheduler sharing one sequencing engine among NUM_REQ requesters.
// Optional DRAIN watchdog with sticky err is enabled by defining RR_SCHED_WATCHDOG_EN.
module rr_job_scheduler
  import rr_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int LEN_W     = 4,
  parameter int DRAIN_MAX = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] job_len,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     eng_in,
  input  logic                     eng_out,
  output logic                     busy,
  output logic                     err
);
  localparam int IDX_W = $clog2(NUM_REQ);

  sched_state_t       state_reg, state_next;
  logic [LEN_W-1:0]   cnt_reg;
  logic [NUM_REQ-1:0] gnt_reg, done_reg;
  logic [IDX_W-1:0]   last_reg, cur_reg;
  logic [LEN_W-1:0]   len_arr [NUM_REQ];
  logic [LEN_W-1:0]   eff_len;
  logic [NUM_REQ-1:0] pick_sel;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               wd_expire;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_len
    assign len_arr[gi] = job_len[gi*LEN_W +: LEN_W];
  end

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (req),
    .last  (last_reg),
    .sel   (pick_sel),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign eff_len = (len_arr[pick_idx] == '0) ? LEN_W'(ZERO_LEN_SUB) : len_arr[pick_idx];

`ifdef RR_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(DRAIN_MAX + 1);
  logic [WD_W-1:0] wd_cnt_reg;
  logic            err_reg;

  assign wd_expire = (state_reg == DRAIN) && eng_out && (wd_cnt_reg == WD_W'(DRAIN_MAX - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      wd_cnt_reg <= (state_reg == DRAIN) ? wd_cnt_reg + 1'b1 : '0;
      if (wd_expire) err_reg <= 1'b1;
    end
  end
  assign err = err_reg;
`else
  assign wd_expire = 1'b0;
  // Only an illegal (non-positive) watchdog limit could ever raise err here.
  assign err = (DRAIN_MAX < 1);
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pick_valid) state_next = RUN;
      RUN:     if (cnt_reg == LEN_W'(1)) state_next = DRAIN;
      DRAIN:   if (!eng_out || wd_expire) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      gnt_reg   <= '0;
      done_reg  <= '0;
      cur_reg   <= '0;
      last_reg  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_reg <= state_next;
      done_reg  <= '0;
      case (state_reg)
        IDLE: if (pick_valid) begin
          gnt_reg <= pick_sel;
          cur_reg <= pick_idx;
          cnt_reg <= eff_len;
        end
        RUN: cnt_reg <= cnt_reg - 1'b1;
        // Release the grant and pulse done on the same edge that enters DONE.
        DRAIN: if (state_next == DONE) begin
          gnt_reg  <= '0;
          done_reg <= gnt_reg;
          last_reg <= cur_reg;
        end
        default: ;
      endcase
    end
  end

  assign gnt    = gnt_reg;
  assign done   = done_reg;
  assign eng_in = (state_reg == RUN);
  assign busy   = (state_reg != IDLE);
endmodule

// File: tb/tb_rr_job_scheduler.sv
// Self-checking bench for rr_job_scheduler with a behavioural engine and arbitration model.
module tb_rr_job_scheduler;
  localparam int NUM_REQ   = 4;
  localparam int LEN_W     = 4;
  localparam int DRAIN_MAX = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] job_len = '0;
  logic [3:0]  gnt, done;
  logic        eng_in, eng_out, busy, err;

  int checks = 0;
  int errors = 0;
  int tail = 0;
  int extra_d = 0;
  int m_last = NUM_REQ - 1;
  logic m_err = 1'b0;

  rr_job_scheduler #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .job_len (job_len),
    .gnt     (gnt),
    .done    (done),
    .eng_in  (eng_in),
    .eng_out (eng_out),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Engine: busy from the cycle after `in` rises until 1 + extra_d cycles after it falls.
  always @(posedge clk or posedge reset) begin
    if (reset) tail <= 0;
    else if (eng_in) tail <= 1 + extra_d;
    else if (tail > 0) tail <= tail - 1;
  end
  assign eng_out = (tail != 0);

  function automatic int pick(input logic [3:0] r, input int last);
    int order[$];
    for (int k = 1; k <= NUM_REQ; k++) order.push_back((last + k) % NUM_REQ);
    foreach (order[i]) if (r[order[i]]) return order[i];
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_job(input logic [3:0] r, input logic [15:0] lens, input int extra, input bit drop);
    int e, len, lat, hi, exp_lat;
    e = pick(r, m_last);
    len = int'(lens[e*4 +: 4]);
    if (len == 0) len = 1;
    exp_lat = len + 2 + extra;
`ifdef RR_SCHED_WATCHDOG_EN
    if (1 + extra >= DRAIN_MAX) begin
      exp_lat = len + DRAIN_MAX;
      m_err = 1'b1;
    end
`endif
    extra_d = extra;
    req = r;
    job_len = lens;
    @(negedge clk);
    chk("gnt_at_grant", gnt, 32'(1) << e);
    chk("eng_in_start", eng_in, 1);
    job_len = $urandom;
    if (drop) req[e] = 1'b0;
    hi = 1;
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done != '0) begin
        lat = c;
        break;
      end
      hi += int'(eng_in);
      chk("gnt_held", gnt, 32'(1) << e);
    end
    chk("done_latency", lat, exp_lat);
    chk("done_onehot", done, 32'(1) << e);
    chk("gnt_low_in_done", gnt, 0);
    chk("eng_in_cycles", hi, len);
    chk("busy_in_done", busy, 1);
    chk("err_flag", err, m_err);
    m_last = e;
    @(negedge clk);
    chk("done_cleared", done, 0);
    chk("idle_after_done", busy, 0);
    chk("eng_in_idle", eng_in, 0);
    $display("job req=%b grant=%0d len=%0d latency=%0d", r, e, len, lat);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_eng_in", eng_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single requester, length 3
    do_job(4'b0001, 16'h0003, 0, 1'b0);
    // All requesting, length 2 each: rotation 0,1,2,3,0
    for (int i = 0; i < 5; i++) do_job(4'b1111, 16'h2222, 0, 1'b0);
    // Wrap-around from last=0: grant 2 then 0
    do_job(4'b0101, 16'h4321, 0, 1'b0);
    do_job(4'b0101, 16'h4321, 0, 1'b0);
    // Zero length treated as one
    do_job(4'b0010, 16'h5505, 0, 1'b0);
    // Randomized traffic with slow engines and dropped requests
    for (int i = 0; i < 30; i++)
      do_job(4'($urandom_range(1, 15)), 16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    // Reset in the second RUN cycle of a 5-cycle job
    extra_d = 0;
    req = 4'b0100;
    job_len = 16'h0500;
    @(negedge clk);
    chk("pre_reset_gnt", gnt, 4'b0100);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_eng_in", eng_in, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    req = '0;
    @(negedge clk);
    reset = 1'b0;
    m_last = NUM_REQ - 1;
    m_err = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", done, 0);
    end
    do_job(4'b1111, 16'h3333, 0, 1'b0);

`ifdef RR_SCHED_WATCHDOG_EN
    // Engine stuck busy in DRAIN: watchdog releases the requester and sets err
    do_job(4'b0001, 16'h0002, 20, 1'b0);
    repeat (25) @(negedge clk);
    do_job(4'b0010, 16'h0020, 0, 1'b0);
    chk("err_sticky", err, 1);
`endif

    req = '0;
    repeat (3) @(negedge clk);
    chk("final_idle", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
